// File: rtl/ivtest_toggle_monitor.sv
// ivtest_toggle_monitor: checks that a clocked 1-bit element's output follows the previous edge's data and counts toggles to pass/fail
module ivtest_toggle_monitor #(
  parameter int PASS_COUNT  = 4,
  parameter int MAX_UNKNOWN = 3,
  parameter int CNT_W       = 8
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             d,
  input  logic             q,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             passed,
  output logic             failed,
  output logic [1:0]       err_code
);
  typedef enum logic [1:0] {IDLE, WAIT_KNOWN, TRACK, DONE} state_e;
  localparam logic [CNT_W-1:0] PASS_V = CNT_W'(PASS_COUNT);
  localparam logic [CNT_W-1:0] MAXU_V = CNT_W'(MAX_UNKNOWN);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, unk_q, unk_d;
  logic             d_reg_q, q_prev_q, passed_q, failed_q, q_unk;
  logic [1:0]       err_q;
  always_comb begin
    q_unk = $isunknown(q);
    unk_d = unk_q + 1'b1;
    cnt_d = (q !== q_prev_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge cp) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      unk_q    <= '0;
      d_reg_q  <= 1'b0;
      q_prev_q <= 1'b0;
      passed_q <= 1'b0;
      failed_q <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      if (state_q != DONE) d_reg_q <= d;
      case (state_q)
        IDLE: state_q <= WAIT_KNOWN;
        WAIT_KNOWN:
          if (q_unk) begin
            unk_q <= unk_d;
            if (unk_d == MAXU_V) begin
              failed_q <= 1'b1;
              err_q    <= 2'b10;
              state_q  <= DONE;
            end
          end else if (q === d_reg_q) begin
            q_prev_q <= q;
            cnt_q    <= '0;
            unk_q    <= '0;
            state_q  <= TRACK;
          end else begin
            failed_q <= 1'b1;
            err_q    <= 2'b01;
            state_q  <= DONE;
          end
        TRACK: begin
          q_prev_q <= q;
          if (q_unk || q !== d_reg_q) begin
            failed_q <= 1'b1;
            err_q    <= q_unk ? 2'b11 : 2'b01;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == PASS_V) begin
              passed_q <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign state      = state_q;
  assign toggle_cnt = cnt_q;
  assign passed     = passed_q;
  assign failed     = failed_q;
  assign err_code   = err_q;
endmodule

// File: tb/tb_ivtest_toggle_monitor.sv
// tb_ivtest_toggle_monitor: randomized and directed stimulus scored against a rule-level reference model
module tb_ivtest_toggle_monitor;
  localparam int PASS_COUNT  = 4;
  localparam int MAX_UNKNOWN = 3;
  localparam int CNT_W       = 8;
  typedef struct {
    int st;
    int tc;
    int ps;
    int fl;
    int ec;
  } exp_t;
  logic             cp = 1'b0;
  logic             rst = 1'b1;
  logic             d = 1'b0;
  logic             q = 1'b0;
  logic [1:0]       state;
  logic [CNT_W-1:0] toggle_cnt;
  logic             passed, failed;
  logic [1:0]       err_code;
  exp_t             exp_q[$];
  int               checks = 0;
  int               failures = 0;
  int               edge_no = 0;
  int               m_phase, m_tc, m_unk, m_ps, m_fl, m_ec;
  logic             m_dreg, m_qprev, last_d;
  ivtest_toggle_monitor #(
    .PASS_COUNT(PASS_COUNT), .MAX_UNKNOWN(MAX_UNKNOWN), .CNT_W(CNT_W)
  ) dut (
    .cp(cp), .rst(rst), .d(d), .q(q), .state(state), .toggle_cnt(toggle_cnt),
    .passed(passed), .failed(failed), .err_code(err_code)
  );
  always #5 cp = ~cp;
  task automatic model_fail(input int code);
    m_fl = 1;
    m_ec = code;
    m_phase = 3;
  endtask
  // phase: 0 idle, 1 waiting for a known q, 2 tracking, 3 finished
  task automatic model(input logic r, input logic dv, input logic qv);
    logic prev_d;
    if (r) begin
      m_phase = 0; m_tc = 0; m_unk = 0; m_ps = 0; m_fl = 0; m_ec = 0;
      m_dreg = 1'b0; m_qprev = 1'b0;
    end else if (m_phase != 3) begin
      prev_d = m_dreg;
      m_dreg = dv;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if ($isunknown(qv)) begin
          m_unk++;
          if (m_unk == MAX_UNKNOWN) model_fail(2);
        end else if (qv === prev_d) begin
          m_qprev = qv; m_tc = 0; m_unk = 0; m_phase = 2;
        end else model_fail(1);
      end else begin
        if ($isunknown(qv)) model_fail(3);
        else if (qv !== prev_d) model_fail(1);
        else begin
          if (qv !== m_qprev && m_tc < (1 << CNT_W) - 1) m_tc++;
          if (m_tc == PASS_COUNT) begin
            m_ps = 1;
            m_phase = 3;
          end
        end
        m_qprev = qv;
      end
    end
  endtask
  task automatic drive(input logic r, input logic dv, input logic qv);
    exp_t e;
    @(negedge cp);
    rst = r;
    d = dv;
    q = qv;
    model(rst, d, q);
    e.st = m_phase; e.tc = m_tc; e.ps = m_ps; e.fl = m_fl; e.ec = m_ec;
    exp_q.push_back(e);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    last_d = 1'b0;
  endtask
  // d alternates 1,0,...; q is x for the first x_first edges and from edge x_from on, else d one edge late
  task automatic nominal(input int n, input int x_first, input int x_from);
    logic dv;
    for (int i = 0; i < n; i++) begin
      dv = (i % 2 == 0);
      drive(1'b0, dv, (i < x_first || i >= x_from) ? 1'bx : last_d);
      last_d = dv;
    end
  endtask
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL edge %0d %s got=%0d want=%0d", edge_no, name, got, want);
    end
  endtask
  always @(posedge cp) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      edge_no++;
      chk("state", int'(state), e.st);
      chk("toggle_cnt", int'(toggle_cnt), e.tc);
      chk("passed", int'(passed), e.ps);
      chk("failed", int'(failed), e.fl);
      chk("err_code", int'(err_code), e.ec);
    end
  end
  initial begin
    logic dv, qv;
    int   wait_cnt;
    do_reset(2); nominal(10, 1, 1000);
    do_reset(2); nominal(14, 1000, 0);
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      dv = (i % 2 == 0);
      drive(1'b0, dv, dv);
    end
    do_reset(2); nominal(8, 1, 4);
    do_reset(2); nominal(4, 1, 1000);
    do_reset(1); nominal(10, 1, 1000);
    do_reset(2);
    for (int i = 0; i < 22; i++) drive(1'b0, 1'b1, (i == 0) ? 1'bx : 1'b1);
    for (int run = 0; run < 40; run++) begin
      do_reset(1 + int'($urandom_range(1)));
      nominal(int'($urandom_range(3)), int'($urandom_range(3, 1)), 1000);
      for (int i = 0; i < 16; i++) begin
        dv = 1'($urandom_range(1));
        case ($urandom_range(11))
          0: qv = 1'bx;
          1: qv = ~last_d;
          2: qv = 1'bz;
          default: qv = last_d;
        endcase
        if ($urandom_range(30) == 0) begin
          do_reset(1);
        end else begin
          drive(1'b0, dv, qv);
          last_d = dv;
        end
      end
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge cp);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ivtest_toggle_monitor.md
Name: ivtest_toggle_monitor

Overview:
- Self-checking consumer stage for a clocked single-bit storage element, such as a UDP D flip-flop driven by a toggling data bit.
- Samples the element's data input and output on each rising clock edge.
- Checks that the output reproduces the previous edge's data, tolerating an initial unknown period.
- Counts valid output toggles and reports pass/fail plus an error code, so a regression bench needs only one status check.

Parameters:
PASS_COUNT, 4, number of valid output toggles needed to declare pass (1..2^CNT_W-1)
MAX_UNKNOWN, 3, consecutive edges q may be x/z before a stuck-X failure (>=1)
CNT_W, 8, width of toggle_cnt and of the internal unknown counter

Ports:
cp  input  1  clock; all state updates on posedge cp
rst  input  1  synchronous active-high reset
d  input  1  data input of monitored element (4-state)
q  input  1  output of monitored element (4-state)
state  output  2  00 IDLE, 01 WAIT_KNOWN, 10 TRACK, 11 DONE
toggle_cnt  output  CNT_W  valid output toggles seen in TRACK
passed  output  1  sticky pass flag
failed  output  1  sticky fail flag
err_code  output  2  00 none, 01 MISMATCH, 10 STUCK_X, 11 X_AFTER_KNOWN

Behaviour:
- One clock, cp. Reset is synchronous and active-high on rst. Inputs are ignored on any edge where rst=1.
- Reset values: state=00, toggle_cnt=0, passed=0, failed=0, err_code=00. Internal registers also clear: d_reg=0, q_prev=0, unk_cnt=0.
- Sampling:
  - q sampled at edge k is the element's value before edge k, so it must equal d_reg (d captured at edge k-1).
  - Bench changes q/d after the edge: nonblocking assignment or #delay.
  - d is captured into d_reg on every non-reset edge in every state except DONE.
- Known value means 0 or 1. Comparisons are case-equality (4-state).
- IDLE: next edge captures d, goes to WAIT_KNOWN. q is not checked.
- WAIT_KNOWN:
  - q unknown: unk_cnt+1. If the new value equals MAX_UNKNOWN: failed=1, err=10, go DONE.
  - q known and q===d_reg: q_prev=q, toggle_cnt=0, unk_cnt=0, go TRACK.
  - q known and q!==d_reg: failed=1, err=01, go DONE.
- TRACK, checks in priority order:
  - q unknown: failed=1, err=11, go DONE.
  - q!==d_reg: failed=1, err=01, go DONE.
  - Otherwise, if q!=q_prev: toggle_cnt+1, saturating at 2^CNT_W-1.
  - If the new toggle_cnt equals PASS_COUNT: passed=1, go DONE.
  - q_prev=q every edge.
- DONE:
  - All outputs and internal registers hold. passed and failed are mutually exclusive.
  - Exit only via rst.
- If d_reg is x/z in TRACK and q is known, that is a MISMATCH (err=01).
- Latencies:
  - Earliest pass: edge 2+PASS_COUNT after reset release (IDLE edge, WAIT_KNOWN edge, PASS_COUNT toggles).
  - Flags are visible immediately after the deciding edge.
- Simultaneous events:
  - rst dominates everything.
  - A pass and a failure cannot occur on the same edge, because failure checks precede the count.
- Reset mid-operation: any state returns to IDLE at the reset edge. No residue from the prior run.
- No combinational paths from inputs to outputs. All outputs are registered.

Test Plan:
1. Nominal pass:
   - Stimulus: rst=1 for 2 edges; d alternates 1,0,1,0,… starting at the first post-reset edge; q=x until edge 2, then q follows d one edge late.
   - Required: state 00→01→10; toggle_cnt reaches 4; passed=1, state=11, err=00, all at edge 6 post-reset.
2. Stuck X:
   - Stimulus: q held x; MAX_UNKNOWN=3.
   - Required: failed=1, err=10, state=11 at the 3rd WAIT_KNOWN edge; toggle_cnt=0; outputs hold for 10 further edges.
3. Mismatch:
   - Stimulus: q driven equal to current d (no one-edge delay) while d alternates.
   - Required: failed=1, err=01 at the first edge where q is known.
4. X after known:
   - Stimulus: nominal run, then q forced x after toggle_cnt=2.
   - Required: failed=1, err=11, toggle_cnt stays 2.
5. Reset mid-TRACK:
   - Stimulus: assert rst for 1 edge when toggle_cnt=2; then rerun the nominal stimulus.
   - Required: state=00 and toggle_cnt=0 after the reset edge; a full nominal pass follows.
6. No toggles:
   - Stimulus: d held 1, q=1 after the initial x period.
   - Required: state=10 for 20 edges, toggle_cnt=0, passed=0, failed=0.
